videofb_arbiter: RTL and testbench
==================================

VIDEOFB_ARBITER -- requirements
Module: videofb_arbiter

Interface
REQ-001 Parameter LINE_BYTES, default 80, number of framebuffer bytes fetched per display line (1..128).
REQ-002 Parameter ADDR_W, default 16, framebuffer byte-address width.
REQ-003 clk  in  1  single clock, shared with pixel timing (25 MHz); all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 line_start  in  1  one-cycle pulse from video timing: swap line banks and begin fetching the next line.
REQ-006 line_base  in  ADDR_W  framebuffer address of the line to fetch, sampled on line_start.
REQ-007 disp_rd_addr  in  7  byte index into the display (read) bank.
REQ-008 disp_rd_data  out  8  display bank byte, registered, 1-cycle latency.
REQ-009 cpu_req / cpu_we  in  1 / 1  CPU access request (level, held until ack) / write enable.
REQ-010 cpu_addr / cpu_wdata  in  ADDR_W / 8  CPU address / write data.
REQ-011 cpu_ack / cpu_rdata  out  1 / 8  one-cycle completion pulse / read data, valid with cpu_ack.
REQ-012 ram_addr / ram_we / ram_wdata  out  ADDR_W / 1 / 8  single-port framebuffer RAM command.
REQ-013 ram_rdata  in  8  RAM read data, valid exactly 1 cycle after the address is issued.
REQ-014 overrun  out  1  sticky flag: line_start arrived while a fetch was still in progress.

Function
REQ-015 FSM states IDLE, FETCH, CPU_ISSUE, CPU_DONE; exactly one RAM command per cycle, or none.
REQ-016 IDLE: line_start -> FETCH; otherwise cpu_req -> CPU_ISSUE; line_start wins over a simultaneous cpu_req.
REQ-017 On line_start, toggle the write bank; the display reads the other bank (the one filled during the previous line).
REQ-018 FETCH issues reads line_base+0 .. line_base+LINE_BYTES-1 on consecutive cycles; address arithmetic wraps modulo 2^ADDR_W.
REQ-019 Each returned byte is written 1 cycle after its read is issued, at index n of the write bank; after the last write the FSM returns to IDLE; total fetch time is LINE_BYTES+1 cycles.
REQ-020 CPU_ISSUE drives ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata; in CPU_DONE, cpu_ack=1, cpu_rdata=ram_rdata (reads), then IDLE. cpu_ack is asserted for exactly one cycle per access.
REQ-021 A CPU access in progress always completes; a line_start arriving during CPU_ISSUE/CPU_DONE is latched and enters FETCH on the cycle after CPU_DONE.
REQ-022 line_start during FETCH: set overrun, abandon the current fetch, toggle banks, restart the fetch at the new line_base.
REQ-023 ram_we=0 whenever no CPU write is issued; the display bank is never written.
REQ-024 disp_rd_addr >= LINE_BYTES returns 0.

Reset
REQ-025 Reset: state=IDLE, write bank=0, cpu_ack=0, cpu_rdata=0, disp_rd_data=0, overrun=0, ram_addr=0, ram_we=0, ram_wdata=0, any pending latched line_start cleared; line-buffer contents are undefined.
REQ-026 Reset asserted mid-fetch or mid-CPU access aborts it at once; no cpu_ack is issued for the aborted access.

Configuration
REQ-027 Macro VIDEOFB_CPU_FAIR_EN: when defined, a pending cpu_req during FETCH is serviced after every 8th issued fetch read (fetch pauses for 2 cycles, then resumes at the next index); this lengthens the fetch by 2 cycles per yield.
REQ-028 When VIDEOFB_CPU_FAIR_EN is undefined, FETCH has strict priority and the CPU waits until IDLE.

Structure
REQ-029 Shared package videofb_pkg holds the FSM state enum, the default LINE_BYTES, ADDR_W and the line-buffer index width.
REQ-030 A sub-module videofb_linebuf implements the 2 x 128 x 8 dual-bank buffer: one write port and one registered read port.

Verification
REQ-031 line_start, line_base=0x0100, RAM model holds byte = addr[7:0] -> 80 reads at 0x0100..0x014F; after the next line_start, disp_rd_addr=5 reads 0x05.
REQ-032 cpu_req write 0x1234<=0xA5 in IDLE, then a read of 0x1234 -> cpu_ack 2 cycles after each request; the read returns 0xA5.
REQ-033 line_start and cpu_req on the same cycle -> fetch first; cpu_ack no sooner than 83 cycles later (macro off).
REQ-034 line_base=0xFFF0 -> addresses wrap from 0xFFFF to 0x0000 after 16 reads.
REQ-035 Second line_start 40 cycles into a fetch -> overrun=1 and stays set; the fetch restarts at the new base; reset clears overrun.
REQ-036 VIDEOFB_CPU_FAIR_EN defined, cpu_req held during a fetch -> cpu_ack within 11 cycles; all 80 line bytes are still correct.

Source files
------------

// File: rtl/videofb_pkg.sv
// Shared types and sizing for the video framebuffer line-fetch arbiter.
// FSM state encoding, default geometry and line-buffer index width.
package videofb_pkg;

    localparam int LINE_BYTES_DEF = 80;
    localparam int ADDR_W_DEF     = 16;
    localparam int LB_IDX_W       = 7;
    localparam int LB_DEPTH       = 1 << LB_IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_CPU_ISSUE,
        S_CPU_DONE
    } state_e;

endpackage

// File: rtl/videofb_arbiter_if.sv
// CPU access bus of the framebuffer arbiter: level request held until a one-cycle ack.
// The master modport is the CPU side, the slave modport is the arbiter side.
interface videofb_arbiter_if
    import videofb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;

    modport master (
        output cpu_req,
        output cpu_we,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_ack,
        input  cpu_rdata
    );

    modport slave (
        input  cpu_req,
        input  cpu_we,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_ack,
        output cpu_rdata
    );

endinterface

// File: rtl/videofb_linebuf.sv
// Dual-bank 2 x 128 x 8 line buffer: one write port, one registered read port.
// Reads at or beyond LINE_BYTES return zero.
module videofb_linebuf
    import videofb_pkg::*;
#(
    parameter int LINE_BYTES = LINE_BYTES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_wr_en,
    input  logic                i_wr_bank,
    input  logic [LB_IDX_W-1:0] i_wr_idx,
    input  logic [7:0]          i_wr_data,
    input  logic                i_rd_bank,
    input  logic [LB_IDX_W-1:0] i_rd_idx,
    output logic [7:0]          o_rd_data
);

    logic [7:0] r_mem [0:2*LB_DEPTH-1];
    logic [7:0] r_rd_data;

    // NOTE: the storage array has no reset; its contents are undefined after reset and a reset term would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_bank, i_wr_idx}] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if ({1'b0, i_rd_idx} >= 8'(LINE_BYTES)) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[{i_rd_bank, i_rd_idx}];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/videofb_arbiter.sv
// Single-port framebuffer RAM arbiter: per-line display fetch into a ping-pong buffer plus CPU access.
// Build option: define VIDEOFB_CPU_FAIR_EN to let a waiting CPU in after every 8th fetch read.
module videofb_arbiter
    import videofb_pkg::*;
#(
    parameter int LINE_BYTES = LINE_BYTES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_line_start,
    input  logic [ADDR_W-1:0]   i_line_base,
    input  logic [LB_IDX_W-1:0] i_disp_rd_addr,
    output logic [7:0]          o_disp_rd_data,
    videofb_arbiter_if.slave    cpu_bus,
    output logic [ADDR_W-1:0]   o_ram_addr,
    output logic                o_ram_we,
    output logic [7:0]          o_ram_wdata,
    input  logic [7:0]          i_ram_rdata,
    output logic                o_overrun
);

    localparam logic [LB_IDX_W-1:0] LAST_IDX = LB_IDX_W'(LINE_BYTES - 1);

    state_e                r_state;
    logic                  r_wr_bank;
    logic [ADDR_W-1:0]     r_fetch_addr;
    logic [ADDR_W-1:0]     r_ram_addr;
    logic                  r_ram_we;
    logic [7:0]            r_ram_wdata;
    logic [LB_IDX_W-1:0]   r_fetch_idx;
    logic [LB_IDX_W-1:0]   r_wb_idx;
    logic                  r_issuing;
    logic                  r_wb_valid;
    logic                  r_ls_pending;
    logic [ADDR_W-1:0]     r_ls_base;
    logic                  r_cpu_ack;
    logic                  r_cpu_we;
    logic                  r_overrun;
    logic                  r_resume;

    logic                  w_start_fetch;
    logic                  w_overrun_hit;
    logic [ADDR_W-1:0]     w_new_base;

    // A line_start seen during a CPU access is deferred to the end of CPU_DONE.
    assign w_start_fetch = (r_state == S_CPU_DONE) ? (i_line_start | r_ls_pending)
                                                   : (i_line_start && (r_state != S_CPU_ISSUE));
    assign w_new_base    = i_line_start ? i_line_base : r_ls_base;
    assign w_overrun_hit = i_line_start && ((r_state == S_FETCH) || r_resume);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_bank    <= 1'b0;
            r_fetch_addr <= '0;
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_wdata  <= '0;
            r_fetch_idx  <= '0;
            r_wb_idx     <= '0;
            r_issuing    <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_ls_pending <= 1'b0;
            r_ls_base    <= '0;
            r_cpu_ack    <= 1'b0;
            r_cpu_we     <= 1'b0;
            r_overrun    <= 1'b0;
            r_resume     <= 1'b0;
        end else begin
            // NOTE: single-cycle strobes default low so any path that does not raise them drops them.
            r_ram_we   <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_wb_valid <= 1'b0;

            if (i_line_start) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_overrun_hit) begin
                r_overrun <= 1'b1;
            end

            if (w_start_fetch) begin
                r_state      <= S_FETCH;
                r_fetch_addr <= w_new_base;
                r_ram_addr   <= w_new_base;
                r_fetch_idx  <= '0;
                r_issuing    <= 1'b1;
                r_ls_pending <= 1'b0;
                r_resume     <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (cpu_bus.cpu_req) begin
                            r_state     <= S_CPU_ISSUE;
                            r_ram_addr  <= cpu_bus.cpu_addr;
                            r_ram_we    <= cpu_bus.cpu_we;
                            r_ram_wdata <= cpu_bus.cpu_wdata;
                            r_cpu_we    <= cpu_bus.cpu_we;
                        end
                    end
                    S_FETCH: begin
                        r_wb_valid <= r_issuing;
                        r_wb_idx   <= r_fetch_idx;
                        if (!r_issuing) begin
                            r_state <= S_IDLE;
                        end else if (r_fetch_idx == LAST_IDX) begin
                            r_issuing <= 1'b0;
                        end else begin
                            r_fetch_idx  <= r_fetch_idx + 1'b1;
                            r_fetch_addr <= r_fetch_addr + 1'b1;
                            r_ram_addr   <= r_fetch_addr + 1'b1;
`ifdef VIDEOFB_CPU_FAIR_EN
                            // Yield after reads 8, 16, ...; the fetch context is kept in r_fetch_*.
                            if (cpu_bus.cpu_req && (r_fetch_idx[2:0] == 3'd7)) begin
                                r_state     <= S_CPU_ISSUE;
                                r_resume    <= 1'b1;
                                r_ram_addr  <= cpu_bus.cpu_addr;
                                r_ram_we    <= cpu_bus.cpu_we;
                                r_ram_wdata <= cpu_bus.cpu_wdata;
                                r_cpu_we    <= cpu_bus.cpu_we;
                            end
`endif
                        end
                    end
                    S_CPU_ISSUE: begin
                        r_state   <= S_CPU_DONE;
                        r_cpu_ack <= 1'b1;
                        if (i_line_start) begin
                            r_ls_pending <= 1'b1;
                            r_ls_base    <= i_line_base;
                        end
                    end
                    S_CPU_DONE: begin
                        if (r_resume) begin
                            r_state    <= S_FETCH;
                            r_ram_addr <= r_fetch_addr;
                            r_resume   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    videofb_linebuf #(
        .LINE_BYTES (LINE_BYTES)
    ) u_linebuf (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (r_wb_valid),
        .i_wr_bank (r_wr_bank),
        .i_wr_idx  (r_wb_idx),
        .i_wr_data (i_ram_rdata),
        .i_rd_bank (~r_wr_bank),
        .i_rd_idx  (i_disp_rd_addr),
        .o_rd_data (o_disp_rd_data)
    );

    assign cpu_bus.cpu_ack   = r_cpu_ack;
    assign cpu_bus.cpu_rdata = (r_cpu_ack && !r_cpu_we) ? i_ram_rdata : 8'h00;
    assign o_ram_addr        = r_ram_addr;
    assign o_ram_we          = r_ram_we;
    assign o_ram_wdata       = r_ram_wdata;
    assign o_overrun         = r_overrun;

endmodule

// File: tb/tb_videofb_arbiter.sv
// Directed bench for videofb_arbiter with a 1-cycle-latency RAM model (unwritten byte = addr[7:0]).
// Expected latencies cover both builds of VIDEOFB_CPU_FAIR_EN.
module tb_videofb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_line_start;
    logic [15:0] i_line_base;
    logic [6:0]  i_disp_rd_addr;
    logic [7:0]  o_disp_rd_data;
    logic [15:0] o_ram_addr;
    logic        o_ram_we;
    logic [7:0]  o_ram_wdata;
    logic [7:0]  i_ram_rdata = 8'h00;
    logic        o_overrun;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] fetch_log [0:79];
    logic [7:0]  ram_mem [logic [15:0]];

    videofb_arbiter_if #(.ADDR_W(16)) cpu_if ();

    videofb_arbiter #(
        .LINE_BYTES (80),
        .ADDR_W     (16)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .i_line_start   (i_line_start),
        .i_line_base    (i_line_base),
        .i_disp_rd_addr (i_disp_rd_addr),
        .o_disp_rd_data (o_disp_rd_data),
        .cpu_bus        (cpu_if),
        .o_ram_addr     (o_ram_addr),
        .o_ram_we       (o_ram_we),
        .o_ram_wdata    (o_ram_wdata),
        .i_ram_rdata    (i_ram_rdata),
        .o_overrun      (o_overrun)
    );

    always #20 clk = ~clk;

    always @(posedge clk) begin
        i_ram_rdata <= ram_mem.exists(o_ram_addr) ? ram_mem[o_ram_addr] : o_ram_addr[7:0];
        if (o_ram_we) ram_mem[o_ram_addr] = o_ram_wdata;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulses line_start and follows n consecutive read addresses; ends in IDLE when n is a full line.
    task automatic fetch_line(input logic [15:0] base, input int n, output int errs);
        i_line_base  = base;
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        errs = 0;
        for (int k = 0; k < n; k++) begin
            fetch_log[k] = o_ram_addr;
            if (o_ram_addr !== base + 16'(k) || o_ram_we !== 1'b0) errs++;
            tick();
        end
        if (n == 80) tick();
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                              input logic ls, input logic [15:0] ls_base,
                              output int lat, output logic [7:0] rd,
                              output logic [15:0] first, output logic first_we);
        cpu_if.cpu_req   = 1'b1;
        cpu_if.cpu_we    = we;
        cpu_if.cpu_addr  = addr;
        cpu_if.cpu_wdata = wd;
        if (ls) begin
            i_line_base  = ls_base;
            i_line_start = 1'b1;
        end
        lat      = -1;
        rd       = 8'h00;
        first    = 16'h0000;
        first_we = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            i_line_start = 1'b0;
            if (k == 1) begin
                first    = o_ram_addr;
                first_we = o_ram_we;
            end
            if (cpu_if.cpu_ack === 1'b1) begin
                lat = k;
                rd  = cpu_if.cpu_rdata;
                break;
            end
        end
        cpu_if.cpu_req = 1'b0;
        tick();
        check("ack_single_pulse", 32'(cpu_if.cpu_ack), 0);
    endtask

    task automatic disp_check(input logic [6:0] idx, input logic [7:0] exp, input string tag);
        i_disp_rd_addr = idx;
        tick();
        check(tag, 32'(o_disp_rd_data), 32'(exp));
    endtask

    task automatic swap_lines(input logic [15:0] base);
        i_line_base  = base;
        i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
    endtask

    initial begin
        int          errs;
        int          lat;
        logic [7:0]  rd;
        logic [15:0] first;
        logic        first_we;

        reset            = 1'b1;
        i_line_start     = 1'b0;
        i_line_base      = '0;
        i_disp_rd_addr   = '0;
        cpu_if.cpu_req   = 1'b0;
        cpu_if.cpu_we    = 1'b0;
        cpu_if.cpu_addr  = '0;
        cpu_if.cpu_wdata = '0;
        repeat (3) tick();
        check("rst_ack",       32'(cpu_if.cpu_ack),   0);
        check("rst_rdata",     32'(cpu_if.cpu_rdata), 0);
        check("rst_overrun",   32'(o_overrun),        0);
        check("rst_ram_addr",  32'(o_ram_addr),       0);
        check("rst_ram_we",    32'(o_ram_we),         0);
        check("rst_ram_wdata", 32'(o_ram_wdata),      0);
        check("rst_disp",      32'(o_disp_rd_data),   0);
        reset = 1'b0;
        tick();

        // Line at 0x0100, then swap: display shows it while 0x0110 fills the other bank.
        fetch_line(16'h0100, 80, errs);
        check("fetch_0100_addrs", 32'(errs), 0);
        check("fetch_0100_last",  32'(fetch_log[79]), 'h014F);
        swap_lines(16'h0110);
        repeat (9) tick();
        disp_check(7'd5,   8'h05, "disp_idx5");
        disp_check(7'd79,  8'h4F, "disp_idx79");
        disp_check(7'd80,  8'h00, "disp_idx80_zero");
        disp_check(7'd127, 8'h00, "disp_idx127_zero");
        repeat (80) tick();

        // CPU write then read back in IDLE.
        cpu_access(1'b1, 16'h1234, 8'hA5, 1'b0, 16'h0, lat, rd, first, first_we);
        check("wr_latency",  32'(lat),      2);
        check("wr_cmd_addr", 32'(first),    'h1234);
        check("wr_cmd_we",   32'(first_we), 1);
        cpu_access(1'b0, 16'h1234, 8'h00, 1'b0, 16'h0, lat, rd, first, first_we);
        check("rd_latency",  32'(lat),      2);
        check("rd_data",     32'(rd),       'hA5);
        check("rd_cmd_we",   32'(first_we), 0);

        // line_start and cpu_req together: the fetch goes first.
        cpu_access(1'b0, 16'h1234, 8'h00, 1'b1, 16'h0400, lat, rd, first, first_we);
        check("ls_wins_first_addr", 32'(first), 'h0400);
`ifdef VIDEOFB_CPU_FAIR_EN
        check("ls_wins_latency_fair", 32'(lat), 10);
`else
        check("ls_wins_latency", 32'(lat), 84);
`endif
        check("ls_wins_rdata", 32'(rd), 'hA5);
        repeat (90) tick();

        // Address wrap at the top of the address space.
        fetch_line(16'hFFF0, 80, errs);
        check("wrap_addrs",  32'(errs), 0);
        check("wrap_idx15",  32'(fetch_log[15]), 'hFFFF);
        check("wrap_idx16",  32'(fetch_log[16]), 'h0000);
        swap_lines(16'h0900);
        disp_check(7'd0,  8'hF0, "wrap_disp0");
        disp_check(7'd15, 8'hFF, "wrap_disp15");
        disp_check(7'd16, 8'h00, "wrap_disp16");
        repeat (85) tick();

        // Overrun: second line_start 40 reads into a fetch.
        fetch_line(16'h0500, 40, errs);
        check("ovr_first_part", 32'(errs), 0);
        check("ovr_clear_before", 32'(o_overrun), 0);
        fetch_line(16'h0523, 80, errs);
        check("ovr_restart_addrs", 32'(errs), 0);
        check("ovr_restart_first", 32'(fetch_log[0]), 'h0523);
        check("ovr_set", 32'(o_overrun), 1);
        swap_lines(16'h0A00);
        check("ovr_sticky", 32'(o_overrun), 1);
        disp_check(7'd3,  8'h26, "ovr_disp3");
        disp_check(7'd79, 8'h72, "ovr_disp79");
        repeat (85) tick();
        reset = 1'b1;
        tick();
        check("ovr_reset_clears", 32'(o_overrun), 0);
        reset = 1'b0;
        tick();

        // CPU request arriving 3 cycles into a fetch.
        swap_lines(16'h0730);
        tick();
        tick();
        cpu_access(1'b0, 16'h1234, 8'h00, 1'b0, 16'h0, lat, rd, first, first_we);
`ifdef VIDEOFB_CPU_FAIR_EN
        check("fair_latency_le11", 32'(lat >= 1 && lat <= 11), 1);
`else
        check("strict_latency", 32'(lat), 81);
`endif
        check("midfetch_rdata", 32'(rd), 'hA5);
        repeat (90) tick();
        swap_lines(16'h0B00);
        disp_check(7'd0,  8'h30, "line_disp0");
        disp_check(7'd7,  8'h37, "line_disp7");
        disp_check(7'd8,  8'h38, "line_disp8");
        disp_check(7'd79, 8'h7F, "line_disp79");
        repeat (85) tick();

        // Reset during a CPU access and during a fetch.
        cpu_if.cpu_req   = 1'b1;
        cpu_if.cpu_we    = 1'b1;
        cpu_if.cpu_addr  = 16'h2222;
        cpu_if.cpu_wdata = 8'h5A;
        tick();
        check("abort_issue_we", 32'(o_ram_we), 1);
        reset          = 1'b1;
        cpu_if.cpu_req = 1'b0;
        tick();
        check("abort_ack",  32'(cpu_if.cpu_ack), 0);
        check("abort_we",   32'(o_ram_we),       0);
        reset = 1'b0;
        tick();
        check("abort_no_late_ack", 32'(cpu_if.cpu_ack), 0);
        swap_lines(16'h0C00);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("abort_fetch_addr", 32'(o_ram_addr), 0);
        reset = 1'b0;
        tick();
        tick();
        check("idle_after_abort", 32'(o_ram_addr), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
